// File: rtl/sa_stream_engine_v2_pkg.sv
// Shared types and helpers for the multi-lane stream engine.
//   state_t   : job FSM states
//   mode_t    : per-job lane operation
//   job_cfg_t : job parameters latched on an accepted start
package sa_engine_pkg;

  localparam int unsigned SIZE_WIDTH = 32;
  localparam int unsigned K_WIDTH    = 16;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERROR} state_t;
  typedef enum logic [1:0] {MODE_PASS, MODE_SCALE, MODE_ACC, MODE_RSVD} mode_t;

  typedef struct packed {
    mode_t                 mode;
    logic [SIZE_WIDTH-1:0] size;
    logic [K_WIDTH-1:0]    acc_len;
    logic [SIZE_WIDTH-1:0] out_goal;
  } job_cfg_t;

  // Reserved mode, or an ACC job whose beat count is not a whole number of groups.
  function automatic logic cfg_invalid(mode_t mode, logic [SIZE_WIDTH-1:0] size,
                                       logic [K_WIDTH-1:0] k);
    logic bad;
    bad = (mode == MODE_RSVD);
    if (mode == MODE_ACC) begin
      if (k == '0) bad = 1'b1;
      else if ((size % SIZE_WIDTH'(k)) != '0) bad = 1'b1;
    end
    return bad;
  endfunction

  // Number of output beats a job produces; divisor forced non-zero for rejected jobs.
  function automatic logic [SIZE_WIDTH-1:0] calc_out_goal(mode_t mode,
                                                          logic [SIZE_WIDTH-1:0] size,
                                                          logic [K_WIDTH-1:0] k);
    logic [SIZE_WIDTH-1:0] div;
    div = (k == '0) ? SIZE_WIDTH'(1) : SIZE_WIDTH'(k);
    return (mode == MODE_ACC) ? (size / div) : size;
  endfunction

endpackage

// File: rtl/sa_stream_engine_v2_if.sv
// AXI-Stream style handshake bundle (tdata/tvalid/tready).
//   master : drives tdata/tvalid, receives tready
//   slave  : receives tdata/tvalid, drives tready
interface sa_stream_engine_v2_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sa_stream_engine_v2_lane_alu.sv
// One lane of the engine: multiply by weight, mode select, K-beat accumulator.
//   enable : a beat is accepted this cycle (updates out and accumulator)
//   clear  : zero the accumulator (new job or abort)
//   last   : this beat closes an accumulation group
//   out    : registered lane result (pipeline stage 0 data)
module sa_lane_alu
  import sa_engine_pkg::*;
#(
  parameter int unsigned ELEM_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clear,
  input  mode_t                 mode,
  input  logic [ELEM_WIDTH-1:0] weight,
  input  logic [ELEM_WIDTH-1:0] in,
  input  logic                  last,
  output logic [ELEM_WIDTH-1:0] out
);

  logic [ELEM_WIDTH-1:0] prod_c;
  logic [ELEM_WIDTH-1:0] sum_c;
  logic [ELEM_WIDTH-1:0] acc_q, acc_d;
  logic [ELEM_WIDTH-1:0] out_q, out_d;

  // Only the low ELEM_WIDTH bits of the product are ever used, so an
  // ELEM_WIDTH-wide multiply is sufficient.
  always_comb begin
    prod_c = in * weight;
    sum_c  = acc_q + prod_c;
    acc_d  = acc_q;
    out_d  = out_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable && (mode == MODE_ACC)) begin
      acc_d = last ? '0 : sum_c;
    end
    if (enable) begin
      case (mode)
        MODE_SCALE: out_d = prod_c;
        MODE_ACC:   out_d = sum_c;
        default:    out_d = in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/sa_stream_engine_v2.sv
// Multi-lane stream engine between DMA read and write streams.
// Ports: clk, rst_n; i_start/i_abort job control; i_mode, i_size_param,
// i_weight, i_acc_len job config; o_busy/o_done/o_error status;
// s_axis (slave stream in), m_axis (master stream out).
// Optional macro SA_ENGINE_PERF_EN adds o_cyc_cnt, o_stall_cnt, o_beat_cnt.
module sa_stream_engine_v2
  import sa_engine_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned ELEM_WIDTH   = 8,
  parameter int unsigned PIPE_LATENCY = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [1:0]             i_mode,
  input  logic [SIZE_WIDTH-1:0]  i_size_param,
  input  logic [ELEM_WIDTH-1:0]  i_weight,
  input  logic [K_WIDTH-1:0]     i_acc_len,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  sa_stream_engine_v2_if.slave   s_axis,
  sa_stream_engine_v2_if.master  m_axis
`ifdef SA_ENGINE_PERF_EN
  ,
  output logic [31:0]            o_cyc_cnt,
  output logic [31:0]            o_stall_cnt,
  output logic [31:0]            o_beat_cnt
`endif
);

  localparam int unsigned DATA_WIDTH = LANES * ELEM_WIDTH;
  localparam int unsigned LAST       = PIPE_LATENCY;

  state_t                  st_q, st_d;
  job_cfg_t                cfg_q, cfg_d;
  logic [ELEM_WIDTH-1:0]   weight_q, weight_d;
  logic [SIZE_WIDTH-1:0]   in_cnt_q, in_cnt_d;
  logic [SIZE_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic [K_WIDTH-1:0]      k_cnt_q, k_cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    start_q, start_d;
  logic                    start_dly_q, start_dly_d;
  logic                    start_pulse_q, start_pulse_d;
  logic [PIPE_LATENCY:0]   vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   pipe_q [1:PIPE_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_d [1:PIPE_LATENCY];
  logic [DATA_WIDTH-1:0]   stage0_data;

  logic advance_c, s_tready_c, accept_c, out_hs_c, last_beat_c;
  logic abort_c, start_acc_c, clear_c, stage0_load_c;

  // Handshake and pipeline control.
  assign advance_c     = !vld_q[LAST] || m_axis.tready;
  assign s_tready_c    = (st_q == RUN) && (in_cnt_q < cfg_q.size) && advance_c;
  assign accept_c      = s_tready_c && s_axis.tvalid;
  assign out_hs_c      = vld_q[LAST] && m_axis.tready;
  assign last_beat_c   = (k_cnt_q == (cfg_q.acc_len - K_WIDTH'(1)));
  assign abort_c       = i_abort && ((st_q == RUN) || (st_q == DRAIN));
  assign start_acc_c   = (st_q == IDLE) && start_pulse_q;
  assign clear_c       = abort_c || start_acc_c;
  // In ACC only the group-closing beat produces a result.
  assign stage0_load_c = accept_c && ((cfg_q.mode != MODE_ACC) || last_beat_c);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sa_lane_alu #(.ELEM_WIDTH(ELEM_WIDTH)) u_alu (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (accept_c),
      .clear  (clear_c),
      .mode   (cfg_q.mode),
      .weight (weight_q),
      .in     (s_axis.tdata[g*ELEM_WIDTH +: ELEM_WIDTH]),
      .last   (last_beat_c),
      .out    (stage0_data[g*ELEM_WIDTH +: ELEM_WIDTH])
    );
  end

  // Job FSM, counters and config latch.
  always_comb begin
    st_d          = st_q;
    cfg_d         = cfg_q;
    weight_d      = weight_q;
    in_cnt_d      = in_cnt_q + SIZE_WIDTH'(accept_c);
    out_cnt_d     = out_cnt_q + SIZE_WIDTH'(out_hs_c);
    k_cnt_d       = k_cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
    start_d       = i_start;
    start_dly_d   = start_q;
    start_pulse_d = start_q && !start_dly_q;

    if (accept_c && (cfg_q.mode == MODE_ACC)) begin
      k_cnt_d = last_beat_c ? '0 : k_cnt_q + K_WIDTH'(1);
    end

    case (st_q)
      IDLE: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        k_cnt_d   = '0;
        busy_d    = 1'b0;
        if (start_pulse_q) begin
          error_d        = 1'b0;
          cfg_d.mode     = mode_t'(i_mode);
          cfg_d.size     = i_size_param;
          cfg_d.acc_len  = i_acc_len;
          cfg_d.out_goal = calc_out_goal(mode_t'(i_mode), i_size_param, i_acc_len);
          weight_d       = i_weight;
          if (cfg_invalid(mode_t'(i_mode), i_size_param, i_acc_len)) begin
            st_d    = ERROR;
            error_d = 1'b1;
          end else if (i_size_param == '0) begin
            st_d   = DONE;
            done_d = 1'b1;
          end else begin
            st_d   = RUN;
            busy_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_c) begin
          st_d   = IDLE;
          busy_d = 1'b0;
        end else if (in_cnt_q == cfg_q.size) begin
          st_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort_c) begin
          st_d   = IDLE;
          busy_d = 1'b0;
        end else if (out_cnt_q == cfg_q.out_goal) begin
          st_d   = DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      DONE:    st_d = IDLE;
      ERROR:   st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Pipeline shifts as a whole only when the output slot can move.
  always_comb begin
    vld_d  = vld_q;
    pipe_d = pipe_q;
    if (abort_c) begin
      vld_d = '0;
    end else if (advance_c) begin
      vld_d     = {vld_q[LAST-1:0], stage0_load_c};
      pipe_d[1] = stage0_data;
      for (int k = 2; k <= int'(LAST); k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= IDLE;
      cfg_q         <= '0;
      weight_q      <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      k_cnt_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      start_q       <= 1'b0;
      start_dly_q   <= 1'b0;
      start_pulse_q <= 1'b0;
      vld_q         <= '0;
      for (int k = 1; k <= int'(LAST); k++) pipe_q[k] <= '0;
    end else begin
      st_q          <= st_d;
      cfg_q         <= cfg_d;
      weight_q      <= weight_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      k_cnt_q       <= k_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      start_q       <= start_d;
      start_dly_q   <= start_dly_d;
      start_pulse_q <= start_pulse_d;
      vld_q         <= vld_d;
      for (int k = 1; k <= int'(LAST); k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign s_axis.tready = s_tready_c;
  assign m_axis.tdata  = pipe_q[LAST];
  assign m_axis.tvalid = vld_q[LAST];
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;

`ifdef SA_ENGINE_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;

  // Counters run only while a job is active and freeze afterwards.
  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    if (start_acc_c) begin
      cyc_cnt_d   = '0;
      stall_cnt_d = '0;
      beat_cnt_d  = '0;
    end else if ((st_q == RUN) || (st_q == DRAIN)) begin
      cyc_cnt_d = cyc_cnt_q + 32'd1;
      if (vld_q[LAST] && !m_axis.tready) stall_cnt_d = stall_cnt_q + 32'd1;
      if (out_hs_c) beat_cnt_d = beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign o_cyc_cnt   = cyc_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_sa_stream_engine_v2.sv
// Scoreboard bench for sa_stream_engine_v2: the driver pushes the expected
// result of each accepted beat (or completed ACC group) into a queue and a
// separate monitor pops and compares on every output handshake.
module tb_sa_stream_engine_v2;
  import sa_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_abort;
  logic [1:0]  i_mode;
  logic [31:0] i_size_param;
  logic [7:0]  i_weight;
  logic [15:0] i_acc_len;
  logic        o_busy, o_done, o_error;
`ifdef SA_ENGINE_PERF_EN
  logic [31:0] o_cyc_cnt, o_stall_cnt, o_beat_cnt;
`endif

  sa_stream_engine_v2_if #(.DATA_WIDTH(32)) s_if ();
  sa_stream_engine_v2_if #(.DATA_WIDTH(32)) m_if ();

  sa_stream_engine_v2 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_mode       (i_mode),
    .i_size_param (i_size_param),
    .i_weight     (i_weight),
    .i_acc_len    (i_acc_len),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .s_axis       (s_if),
    .m_axis       (m_if)
`ifdef SA_ENGINE_PERF_EN
    ,
    .o_cyc_cnt    (o_cyc_cnt),
    .o_stall_cnt  (o_stall_cnt),
    .o_beat_cnt   (o_beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          tready_seen = 0;
  int          first_valid_cyc = -1;
  int          first_acc_cyc = -1;
  int          ready_mode = 0;
  int          rcnt = 0;
  bit          stall_pend = 1'b0;
  logic [31:0] held_data;
  logic [31:0] exp_q[$];
  logic [31:0] directed_q[$];
  logic [31:0] stim_q[$];
  logic [31:0] grp[$];
  int          cur_mode, cur_k;
  logic [7:0]  cur_w;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Reference: each lane is an independent unsigned byte, product kept mod 256.
  function automatic logic [31:0] scale_model(input logic [31:0] d, input logic [7:0] w);
    logic [31:0] r;
    int unsigned lane;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      lane = ((d >> (8 * i)) & 32'hFF) * 32'(w);
      r = r | (32'(lane % 256) << (8 * i));
    end
    return r;
  endfunction

  function automatic logic [31:0] acc_model();
    logic [31:0] r;
    int unsigned sum;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      sum = 0;
      foreach (grp[b]) sum += (((grp[b] >> (8 * i)) & 32'hFF) * 32'(cur_w)) % 256;
      r = r | (32'(sum % 256) << (8 * i));
    end
    return r;
  endfunction

  function automatic void model_accept(input logic [31:0] d);
    logic [31:0] e;
    bit produce;
    produce = 1'b1;
    e = d;
    if (cur_mode == 2) begin
      grp.push_back(d);
      if (grp.size() == cur_k) begin
        e = acc_model();
        grp.delete();
      end else begin
        produce = 1'b0;
      end
    end else if (cur_mode == 1) begin
      e = scale_model(d, cur_w);
    end
    if (produce) begin
      if (directed_q.size() != 0) e = directed_q.pop_front();
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Output-side ready pattern: always, one cycle in three, or random.
  always @(negedge clk) begin
    rcnt++;
    case (ready_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ((rcnt % 3) == 0);
      default: m_if.tready = ($urandom_range(3, 0) != 0);
    endcase
  end

  // Monitor: values sampled mid-low-phase are the ones the next rising edge uses.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (stall_pend) begin
        chk("stall_hold_valid", 32'(m_if.tvalid), 32'd1);
        chk("stall_hold_data", m_if.tdata, held_data);
      end
      stall_pend = 1'b0;
      if (m_if.tvalid && !m_if.tready) begin
        chk("s_tready_low_when_stalled", 32'(s_if.tready), 32'd0);
        stall_pend = 1'b1;
        held_data  = m_if.tdata;
      end
      if (m_if.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output: got 0x%08h expected no output", m_if.tdata);
        end else begin
          chk("m_tdata", m_if.tdata, exp_q.pop_front());
        end
      end
      if (o_done) done_cnt++;
      if (s_if.tready) tready_seen++;
    end
  end

  task automatic start_job(input int mode, input int size, input int w, input int k);
    i_mode       = 2'(mode);
    i_size_param = 32'(size);
    i_weight     = 8'(w);
    i_acc_len    = 16'(k);
    i_start      = 1'b1;
    cur_mode     = mode;
    cur_w        = 8'(w);
    cur_k        = k;
    grp.delete();
    first_valid_cyc = -1;
    first_acc_cyc   = -1;
    repeat (2) @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_busy();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (o_busy) seen = 1'b1;
      else @(negedge clk);
    end
    chk("busy_rise", 32'(seen), 32'd1);
  endtask

  task automatic drive_beat(input logic [31:0] d, input int gap);
    int guard;
    bit fin;
    guard = 0;
    fin   = 1'b0;
    if (gap > 0) begin
      s_if.tvalid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    while (!fin) begin
      #1;
      if (s_if.tready) begin
        if (first_acc_cyc < 0) first_acc_cyc = cyc + 1;
        model_accept(d);
        fin = 1'b1;
      end else if (guard > 2000) begin
        chk("accept_timeout", 32'd0, 32'd1);
        fin = 1'b1;
      end
      guard++;
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      #1;
      if (o_done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) chk("busy_low_at_done", 32'(o_busy), 32'd0);
  endtask

  task automatic run_job(input int mode, input int size, input int w, input int k, input int gap_max);
    int d0;
    logic [31:0] beat;
    d0 = done_cnt;
    start_job(mode, size, w, k);
    wait_busy();
    chk("error_clear_on_start", 32'(o_error), 32'd0);
    // Config inputs are don't-care once the job is latched.
    i_mode       = 2'($urandom_range(3, 0));
    i_weight     = 8'($urandom);
    i_acc_len    = 16'($urandom);
    i_size_param = $urandom;
    @(negedge clk);
    for (int b = 0; b < size; b++) begin
      beat = (stim_q.size() != 0) ? stim_q.pop_front() : $urandom;
      drive_beat(beat, int'($urandom_range(gap_max, 0)));
    end
    wait_done(3000);
    repeat (2) @(negedge clk);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, t0;
    rst_n = 1'b0;
    i_start = 1'b0; i_abort = 1'b0; i_mode = '0; i_size_param = '0;
    i_weight = '0; i_acc_len = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_s_tready", 32'(s_if.tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_m_tdata", m_if.tdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // PASS with exact latency.
    ready_mode = 0;
    stim_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    run_job(0, 4, 0, 1, 0);
    chk("pass_latency", 32'(first_valid_cyc - first_acc_cyc), 32'd8);
    chk("queue_empty_pass", 32'(exp_q.size()), 32'd0);

    // SCALE with per-lane truncation.
    directed_q = '{32'h80C06030};
    stim_q     = '{32'h80402010};
    run_job(1, 1, 3, 1, 0);
    chk("queue_empty_scale", 32'(exp_q.size()), 32'd0);

    // ACC K=4 over 8 beats of ones.
    directed_q = '{32'h04040404, 32'h04040404};
    for (int i = 0; i < 8; i++) stim_q.push_back(32'h01010101);
    run_job(2, 8, 1, 4, 0);
    chk("queue_empty_acc", 32'(exp_q.size()), 32'd0);

    // Backpressure: ready one cycle in three.
    ready_mode = 1;
    run_job(0, 16, 0, 1, 0);
    chk("queue_empty_bp", 32'(exp_q.size()), 32'd0);
    ready_mode = 0;

    // Parameter error: ACC size not a multiple of K.
    d0 = done_cnt;
    t0 = tready_seen;
    start_job(2, 10, 1, 4);
    repeat (6) @(negedge clk);
    #1;
    chk("err_flag", 32'(o_error), 32'd1);
    chk("err_busy", 32'(o_busy), 32'd0);
    chk("err_no_done", 32'(done_cnt - d0), 32'd0);
    chk("err_no_tready", 32'(tready_seen - t0), 32'd0);
    @(negedge clk);
    run_job(0, 2, 0, 1, 0);
    chk("queue_empty_after_err", 32'(exp_q.size()), 32'd0);

    // size==0 completes three cycles after the start rise.
    @(negedge clk);
    i_mode = 2'd0; i_size_param = 32'd0; i_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("size0_done_early", 32'(o_done), 32'd0);
    @(posedge clk);
    #1;
    chk("size0_done", 32'(o_done), 32'd1);
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);

    // Abort in DRAIN with three beats in flight.
    d0 = done_cnt;
    start_job(0, 3, 0, 1);
    wait_busy();
    for (int b = 0; b < 3; b++) drive_beat($urandom, 0);
    @(negedge clk);
    i_abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    i_abort = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_job(1, 5, 7, 1, 1);
    chk("queue_empty_post_abort", 32'(exp_q.size()), 32'd0);

    // Randomized jobs with random gaps and backpressure.
    for (int j = 0; j < 6; j++) begin
      int m, w, k, sz;
      m = int'($urandom_range(2, 0));
      w = int'($urandom_range(255, 0));
      if (m == 2) begin
        k  = int'($urandom_range(4, 1));
        sz = k * int'($urandom_range(4, 1));
      end else begin
        k  = int'($urandom_range(3, 0));
        sz = int'($urandom_range(12, 1));
      end
      ready_mode = 2;
      run_job(m, sz, w, k, 2);
      chk("queue_empty_rand", 32'(exp_q.size()), 32'd0);
    end
    ready_mode = 0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sa_stream_engine_v2.md
# sa_stream_engine_v2

Multi-lane, mode-configurable successor to the single-lane stream engine: sits between the DMA read stream and DMA write stream inside the systolic-array IP. Splits each beat into LANES independent elements and applies pass-through, scale-by-weight or K-beat accumulation. Results traverse a fixed-latency pipeline that stalls correctly under output backpressure. Adds abort and parameter-error reporting.

## Interface
- LANES, 4, number of independent element lanes per beat
- ELEM_WIDTH, 8, bits per lane element; DATA_WIDTH = LANES*ELEM_WIDTH (localparam)
- PIPE_LATENCY, 8, pipeline stages from input accept to output valid (>=1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- i_start  in  1  level; internally rising-edge detected
- i_abort  in  1  level; terminates a running job
- i_mode  in  2  0=PASS, 1=SCALE, 2=ACC, 3=reserved (error)
- i_size_param  in  32  input beats for the job
- i_weight  in  ELEM_WIDTH  scale factor, used by SCALE/ACC
- i_acc_len  in  16  K, beats per accumulated output (ACC only)
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse on normal completion
- o_error  out  1  sticky; cleared by the next accepted start
- s_tdata/s_tvalid/s_tready  in/in/out  DATA_WIDTH/1/1  input AXI-Stream
- m_tdata/m_tvalid/m_tready  out/out/in  DATA_WIDTH/1/1  output AXI-Stream

## Operation
- Mode, size, weight and K are latched on the registered start pulse; later changes are ignored until the next job.
- FSM states:
  - IDLE: busy=0, counters cleared. On start pulse:
    - mode==3, or ACC with K==0, or ACC with size%K!=0 → ERROR.
    - size==0 → DONE.
    - otherwise → RUN; out_goal = size (PASS/SCALE) or size/K (ACC).
  - RUN: accept beats; when in_cnt==size → DRAIN.
  - DRAIN: count output handshakes; when out_cnt==out_goal → DONE.
  - DONE: o_done=1 for one cycle → IDLE.
  - ERROR: o_error set, busy=0, one cycle → IDLE.
- i_abort in RUN/DRAIN: clear all pipeline valids, → IDLE; no o_done; o_error unchanged.
- Start pulses are ignored while busy.
- Lane arithmetic (unsigned; lane i = bits [i*ELEM_WIDTH +: ELEM_WIDTH]):
  - PASS: out = in.
  - SCALE: out = low ELEM_WIDTH bits of in*weight.
  - ACC: acc += low bits of in*weight (wraps modulo 2^ELEM_WIDTH). Stage 0 becomes valid only on the K-th beat, carrying the final sum; the accumulator then clears.
- Lanes never interact: no carries between lanes.

## Timing
- Reset values: o_busy=0, o_done=0, o_error=0, s_tready=0, m_tvalid=0, m_tdata=0, all pipe valids 0, FSM=IDLE.
- Start: i_start rising at edge n → pulse registered at n+1 → RUN (busy=1) at n+2.
- Stall rule: advance = !pipe_valid[last] || m_tready. The whole pipe shifts only when advance is high.
- s_tready = (st==RUN) && (in_cnt<size) && advance. It never depends on s_tvalid.
- Latency without stalls: a beat accepted at edge t gives m_tvalid at edge t+PIPE_LATENCY. In ACC, the K-th beat sets this timing.
- m_tdata/m_tvalid hold stable while m_tvalid && !m_tready.
- Simultaneous accept and output are legal every cycle; full throughput is 1 beat/cycle.
- o_done is asserted the cycle after the final output handshake is counted.

## Configuration
- SA_ENGINE_PERF_EN:
  - Defined: adds outputs o_cyc_cnt[31:0] (cycles busy), o_stall_cnt[31:0] (cycles with m_tvalid && !m_tready) and o_beat_cnt[31:0] (output handshakes). All three clear on an accepted start and freeze at job end.
  - Undefined: the ports and logic are absent; all other behaviour is identical.

## Structure
- Package sa_engine_pkg: state_t {IDLE, RUN, DRAIN, DONE, ERROR}, mode_t {MODE_PASS, MODE_SCALE, MODE_ACC, MODE_RSVD}.
- Sub-module sa_lane_alu: one lane's multiply, mode mux and accumulator. Instantiated LANES times via generate. Ports: clk, rst_n, enable, clear, mode, weight, in, last, out.

## Test plan
- PASS, size=4, m_tready=1, beats 0x04030201..: identical data out, first m_tvalid exactly 8 cycles after first accept; o_done once; busy drops with done.
- SCALE, weight=3, beat 0x80402010: output 0x80C06030, each lane truncated independently.
- ACC, K=4, size=8, weight=1, all lanes=0x01 per beat: two outputs of 0x04040404; out_cnt=2 at DONE.
- Backpressure: PASS size=16, m_tready toggled 1-of-3: no beat lost or duplicated, m_tdata stable while stalled, s_tready low when pipe full and stalled.
- Errors: ACC size=10 K=4 → o_error=1, no s_tready, no o_done; next valid start clears o_error. size=0 → o_done 3 cycles after i_start rise.
- Abort mid-DRAIN with 3 beats in flight: m_tvalid low next cycle, IDLE, no o_done; a new job afterwards runs correctly.
